iq_deinterleave: RTL and testbench
==================================

IQ_DEINTERLEAVE -- requirements
Module: iq_deinterleave

Interface
REQ-001 Parameter N_CH, default 4: number of I/Q channel pairs per frame, range 1..16.
REQ-002 Parameter DW, default 21: signed sample word width.
REQ-003 Parameter CW, default 16: width of frame and drop counters.
REQ-004 sample_clk  in  1  sole clock; all logic on rising edge.
REQ-005 sample_rst  in  1  synchronous, active-high reset.
REQ-006 stream_in  in  DW  serial word, order I0,Q0,I1,Q1,...,I(N_CH-1),Q(N_CH-1).
REQ-007 strobe_in  in  1  word valid; held high for one contiguous burst per frame.
REQ-008 hold  in  1  freezes iq_out for readout; frames completing while high are dropped.
REQ-009 clr_err  in  1  single-cycle clear of err_short and err_long.
REQ-010 iq_out  out  2*N_CH*DW  parallel frame; word k at bits [k*DW +: DW].
REQ-011 strobe_out  out  1  one-cycle pulse when iq_out updates.
REQ-012 frame_cnt  out  CW  count of frames delivered to iq_out.
REQ-013 drop_cnt  out  CW  count of complete frames discarded due to hold.
REQ-014 err_short, err_long  out  1 each  sticky burst-length error flags.

Function
REQ-015 States: IDLE (no burst), COLLECT (burst in progress, idx < 2*N_CH), OVERRUN (burst exceeded 2*N_CH words).
REQ-016 IDLE -> COLLECT on strobe_in high; that word is stored at shadow index 0, idx becomes 1.
REQ-017 In COLLECT, each strobe_in-high cycle stores stream_in at shadow[idx] and increments idx.
REQ-018 On storing word 2*N_CH-1: frame complete; next state IDLE if strobe_in then falls, else OVERRUN on a further high cycle.
REQ-019 Frame complete with hold low: shadow copied to iq_out, strobe_out pulses, frame_cnt increments; all on the cycle after the last word (latency 1).
REQ-020 Frame complete with hold high: iq_out unchanged, no strobe_out, drop_cnt increments, latency 1.
REQ-021 hold sampled on the cycle the last word is captured.
REQ-022 strobe_in low in COLLECT with 0 < idx < 2*N_CH: burst discarded, err_short set, return to IDLE, no counter change.
REQ-023 Any strobe_in-high cycle after a complete frame in the same burst: word ignored, err_long set, OVERRUN until strobe_in low, then IDLE; already-delivered frame stands.
REQ-024 strobe_in low in IDLE: no action.
REQ-025 err_short/err_long remain set until clr_err; if clr_err and a new error coincide, the flag ends set.
REQ-026 frame_cnt and drop_cnt wrap modulo 2^CW without saturation or flag.
REQ-027 Samples passed bit-exact; no sign extension, rounding or reordering within a word.

Reset
REQ-028 sample_rst forces IDLE, idx=0, shadow and iq_out to 0, strobe_out=0, frame_cnt=0, drop_cnt=0, err_short=0, err_long=0.
REQ-029 Reset mid-burst discards the partial frame; words with strobe_in high during reset are ignored; the first burst after release starts at index 0 only if strobe_in was low in the first cycle after release, otherwise that burst is treated as OVERRUN (ignored, no error).

Structure
REQ-030 Shared package vvm_dsp_pkg holds state enum and the frame-length constant function 2*N_CH.
REQ-031 One sub-module natural: iq_deint_ctrl (state machine, idx, error flags); datapath registers in top level.

Verification
REQ-032 N_CH=4, DW=21, burst of 8 words 1..8 -> strobe_out one cycle after word 8, iq_out word k = k+1, frame_cnt=1.
REQ-033 Burst of 5 words -> no strobe_out, err_short=1, frame_cnt unchanged; clr_err -> err_short=0; next 8-word burst delivered normally.
REQ-034 Burst of 10 words -> frame of first 8 delivered, words 9-10 ignored, err_long=1.
REQ-035 hold=1 during three full bursts -> iq_out frozen, drop_cnt=3, frame_cnt unchanged; hold=0 then one burst -> delivered.
REQ-036 sample_rst asserted after word 4 of a burst, released with strobe_in low -> all outputs 0, next full burst delivered with frame_cnt=1.
REQ-037 Preload 2^CW-1 frames (CW=4: 15 bursts) then one more -> frame_cnt wraps to 0, strobe_out still pulses.

Source files
------------

// File: rtl/vvm_dsp_pkg.sv
// Shared DSP package: frame-assembly FSM states and frame-length helper.
// Used by the IQ deinterleaver control and datapath.
package vvm_dsp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    OVERRUN = 2'd2
  } state_t;

  // Words per frame: one I and one Q word per channel.
  function automatic int frame_len(input int n_ch);
    return 2 * n_ch;
  endfunction

endpackage

// File: rtl/iq_deint_ctrl.sv
// Burst framing control for the IQ deinterleaver.
// Tracks word index, frame completion and sticky burst-length errors.
module iq_deint_ctrl
  import vvm_dsp_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int IW   = 4
) (
  input  logic          sample_clk,
  input  logic          sample_rst,
  input  logic          strobe_in,
  input  logic          clr_err,
  output logic          wr_en,
  output logic [IW-1:0] wr_idx,
  output logic          last,
  output logic          err_short,
  output logic          err_long
);

  localparam int FL = frame_len(N_CH);
  localparam logic [IW-1:0] FL_W  = IW'(FL);
  localparam logic [IW-1:0] FL_M1 = IW'(FL - 1);

  state_t        state, state_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic          post_rst;
  logic          set_short, set_long;

  // State, index, post-reset marker and sticky error flags.
  // idx == FL inside COLLECT means the frame is complete and the
  // burst has not yet ended.
  always_ff @(posedge sample_clk) begin
    if (sample_rst) begin
      state     <= IDLE;
      idx       <= '0;
      post_rst  <= 1'b1;
      err_short <= 1'b0;
      err_long  <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      post_rst  <= 1'b0;
      err_short <= set_short | (err_short & ~clr_err);
      err_long  <= set_long | (err_long & ~clr_err);
    end
  end

  // Next-state logic; a burst already high right after reset is
  // swallowed as OVERRUN without raising an error.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    unique case (state)
      IDLE: begin
        if (strobe_in) begin
          if (post_rst) begin
            state_nxt = OVERRUN;
          end else begin
            state_nxt = COLLECT;
            idx_nxt   = IW'(1);
          end
        end
      end
      COLLECT: begin
        if (!strobe_in) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end else if (idx == FL_W) begin
          state_nxt = OVERRUN;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + IW'(1);
        end
      end
      OVERRUN: begin
        idx_nxt = '0;
        if (!strobe_in) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  // Write strobes for the shadow frame and error set pulses.
  always_comb begin
    wr_en     = 1'b0;
    wr_idx    = '0;
    last      = 1'b0;
    set_short = 1'b0;
    set_long  = 1'b0;
    unique case (state)
      IDLE: begin
        wr_en = strobe_in & ~post_rst;
      end
      COLLECT: begin
        wr_idx    = idx;
        wr_en     = strobe_in & (idx != FL_W);
        last      = strobe_in & (idx == FL_M1);
        set_short = ~strobe_in & (idx != FL_W);
        set_long  = strobe_in & (idx == FL_W);
      end
      default: begin
        wr_en = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/iq_deinterleave.sv
// Serial I/Q burst to parallel frame deinterleaver.
// Collects 2*N_CH words into a shadow frame, publishes on completion.
module iq_deinterleave
  import vvm_dsp_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int DW   = 21,
  parameter int CW   = 16
) (
  input  logic                   sample_clk,
  input  logic                   sample_rst,
  input  logic [DW-1:0]          stream_in,
  input  logic                   strobe_in,
  input  logic                   hold,
  input  logic                   clr_err,
  output logic [2*N_CH*DW-1:0]   iq_out,
  output logic                   strobe_out,
  output logic [CW-1:0]          frame_cnt,
  output logic [CW-1:0]          drop_cnt,
  output logic                   err_short,
  output logic                   err_long
);

  localparam int FL = frame_len(N_CH);
  localparam int IW = $clog2(FL + 1);
  localparam int FW = FL * DW;

  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic          last;
  logic [FW-1:0] shadow, frame_nxt;

  iq_deint_ctrl #(
    .N_CH (N_CH),
    .IW   (IW)
  ) u_ctrl (
    .sample_clk (sample_clk),
    .sample_rst (sample_rst),
    .strobe_in  (strobe_in),
    .clr_err    (clr_err),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .last       (last),
    .err_short  (err_short),
    .err_long   (err_long)
  );

  // Shadow frame with the current word merged in, so the last word
  // can be published on the same edge that captures it.
  always_comb begin
    frame_nxt = shadow;
    for (int k = 0; k < FL; k++) begin
      if (wr_en && wr_idx == IW'(k)) begin
        frame_nxt[k*DW +: DW] = stream_in;
      end
    end
  end

  // Shadow capture, frame publication and frame/drop counters.
  always_ff @(posedge sample_clk) begin
    if (sample_rst) begin
      shadow     <= '0;
      iq_out     <= '0;
      strobe_out <= 1'b0;
      frame_cnt  <= '0;
      drop_cnt   <= '0;
    end else begin
      shadow     <= frame_nxt;
      strobe_out <= last & ~hold;
      if (last && !hold) begin
        iq_out    <= frame_nxt;
        frame_cnt <= frame_cnt + CW'(1);
      end
      if (last && hold) begin
        drop_cnt <= drop_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_iq_deinterleave.sv
// Scoreboard bench for iq_deinterleave (N_CH=4, DW=21, CW=4).
// Directed bursts push expected frames; a monitor pops on strobe_out.
module tb_iq_deinterleave;

  localparam int N_CH = 4;
  localparam int DW   = 21;
  localparam int CW   = 4;
  localparam int FL   = 2 * N_CH;
  localparam int FW   = FL * DW;

  logic          clk = 1'b0;
  logic          sample_rst = 1'b1;
  logic [DW-1:0] stream_in = '0;
  logic          strobe_in = 1'b0;
  logic          hold = 1'b0;
  logic          clr_err = 1'b0;
  logic [FW-1:0] iq_out;
  logic          strobe_out;
  logic [CW-1:0] frame_cnt;
  logic [CW-1:0] drop_cnt;
  logic          err_short;
  logic          err_long;

  iq_deinterleave #(
    .N_CH (N_CH),
    .DW   (DW),
    .CW   (CW)
  ) dut (
    .sample_clk (clk),
    .sample_rst (sample_rst),
    .stream_in  (stream_in),
    .strobe_in  (strobe_in),
    .hold       (hold),
    .clr_err    (clr_err),
    .iq_out     (iq_out),
    .strobe_out (strobe_out),
    .frame_cnt  (frame_cnt),
    .drop_cnt   (drop_cnt),
    .err_short  (err_short),
    .err_long   (err_long)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [FW-1:0] frame;
    logic [CW-1:0] cnt;
    int            at;
  } exp_t;

  exp_t q[$];

  int total = 0;
  int bad   = 0;

  logic [FW-1:0] exp_frame = '0;
  logic [CW-1:0] exp_cnt   = '0;
  logic [CW-1:0] exp_drop  = '0;
  logic          exp_short = 1'b0;
  logic          exp_long  = 1'b0;

  task automatic chk(input string name, input logic [FW-1:0] got,
                     input logic [FW-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Monitor: every strobe_out must match the oldest expected frame.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (strobe_out === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_strobe", FW'(1), FW'(0));
        end else begin
          e = q.pop_front();
          chk("strobe_cycle", FW'(cyc), FW'(e.at));
          chk("frame", iq_out, e.frame);
          chk("frame_cnt_at_strobe", FW'(frame_cnt), FW'(e.cnt));
        end
      end
    end
  end

  task automatic burst(input int n, input logic [DW-1:0] base,
                       input logic hv);
    logic [FW-1:0] f;
    logic [DW-1:0] w;
    f = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      w         = base + DW'(k);
      strobe_in = 1'b1;
      stream_in = w;
      hold      = hv;
      if (k < FL) f[k*DW +: DW] = w;
      if (k == FL - 1) begin
        if (hv) begin
          exp_drop++;
        end else begin
          exp_cnt++;
          exp_frame = f;
          q.push_back('{f, exp_cnt, cyc + 1});
        end
      end
    end
    @(negedge clk);
    strobe_in = 1'b0;
    stream_in = '0;
    hold      = 1'b0;
    if (n < FL) exp_short = 1'b1;
    if (n > FL) exp_long = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    @(negedge clk);
    chk({tag, ".iq_out"}, iq_out, exp_frame);
    chk({tag, ".frame_cnt"}, FW'(frame_cnt), FW'(exp_cnt));
    chk({tag, ".drop_cnt"}, FW'(drop_cnt), FW'(exp_drop));
    chk({tag, ".err_short"}, FW'(err_short), FW'(exp_short));
    chk({tag, ".err_long"}, FW'(err_long), FW'(exp_long));
  endtask

  task automatic clear_errs();
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err   = 1'b0;
    exp_short = 1'b0;
    exp_long  = 1'b0;
  endtask

  task automatic model_reset();
    exp_frame = '0;
    exp_cnt   = '0;
    exp_drop  = '0;
    exp_short = 1'b0;
    exp_long  = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    sample_rst = 1'b0;
    check_state("reset");
    chk("reset.strobe_out", FW'(strobe_out), FW'(0));

    burst(8, 21'd1, 1'b0);
    check_state("basic");

    burst(5, 21'd100, 1'b0);
    check_state("short");
    clear_errs();
    check_state("short_clr");
    burst(8, 21'h1FFFF0, 1'b0);
    check_state("after_short");

    burst(10, 21'd200, 1'b0);
    check_state("long");
    clear_errs();

    burst(8, 21'd300, 1'b1);
    burst(8, 21'd400, 1'b1);
    burst(8, 21'd500, 1'b1);
    check_state("hold3");
    burst(8, 21'h0ABCDE, 1'b0);
    check_state("after_hold");

    // Reset after word 4, strobe still high into reset, release low.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      strobe_in = 1'b1;
      stream_in = DW'(k + 700);
      if (k == 4) sample_rst = 1'b1;
    end
    @(negedge clk);
    strobe_in = 1'b0;
    @(negedge clk);
    sample_rst = 1'b0;
    model_reset();
    check_state("mid_rst");
    burst(8, 21'd800, 1'b0);
    check_state("mid_rst_burst");

    // Release reset while strobe_in is high: that burst is ignored.
    @(negedge clk);
    sample_rst = 1'b1;
    strobe_in  = 1'b1;
    stream_in  = DW'(900);
    @(negedge clk);
    sample_rst = 1'b0;
    model_reset();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      stream_in = DW'(901 + k);
    end
    @(negedge clk);
    strobe_in = 1'b0;
    check_state("rst_high_release");

    for (int b = 0; b < 15; b++) begin
      burst(8, DW'(1000 + 16 * b), 1'b0);
    end
    check_state("pre_wrap");
    burst(8, 21'h1F0F0F, 1'b0);
    check_state("wrap");

    repeat (3) @(negedge clk);
    chk("queue_drained", FW'(q.size()), FW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
